// File: rtl/ql_al4s3b_cell_macro.sv
// EOS S3 fabric clock/reset macro: two even dividers with per-domain resets.
// Optional slow demo clock compiled in with QL_SLOW_CLK_EN.
module ql_clk_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic dclk,
  output logic drst
);
  localparam int HALF = DIV / 2;
  localparam int W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [W-1:0] TERM = W'(HALF - 1);

  logic [W-1:0] cnt;
  logic         term;

  assign term = (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      dclk <= 1'b0;
    end else if (term) begin
      cnt  <= '0;
      dclk <= ~dclk;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // Domain reset drops on the edge that makes the first rising clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drst <= 1'b1;
    else if (run && term && !dclk)
      drst <= 1'b0;
  end
endmodule

module ql_al4s3b_cell_macro #(
  parameter int CLK0_DIV        = 2,
  parameter int CLK1_DIV        = 4,
  parameter int RST_SYNC_STAGES = 2,
  parameter int TICK_COUNT      = 40000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic Sys_Clk0,
  output logic Sys_Clk0_Rst,
  output logic Sys_Clk1,
  output logic Sys_Clk1_Rst
`ifdef QL_SLOW_CLK_EN
  ,
  output logic Slow_Clk
`endif
);
  logic [RST_SYNC_STAGES-1:0] sync;
  logic                       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sync <= '0;
    else
      sync <= {sync[RST_SYNC_STAGES-2:0], 1'b1};
  end

  assign run = sync[RST_SYNC_STAGES-1];

  ql_clk_div #(.DIV(CLK0_DIV)) u_div0 (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .dclk  (Sys_Clk0),
    .drst  (Sys_Clk0_Rst)
  );

  ql_clk_div #(.DIV(CLK1_DIV)) u_div1 (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .dclk  (Sys_Clk1),
    .drst  (Sys_Clk1_Rst)
  );

`ifdef QL_SLOW_CLK_EN
  localparam int SW = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
  localparam logic [SW-1:0] STERM = SW'(TICK_COUNT);

  logic [SW-1:0] scnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt     <= '0;
      Slow_Clk <= 1'b0;
    end else if (!run) begin
      scnt     <= '0;
      Slow_Clk <= 1'b0;
    end else if (scnt == STERM) begin
      scnt     <= '0;
      Slow_Clk <= ~Slow_Clk;
    end else begin
      scnt <= scnt + SW'(1);
    end
  end
`endif
endmodule

// File: tb/tb_ql_al4s3b_cell_macro.sv
// Directed bench for ql_al4s3b_cell_macro: default build plus a DIV=6 build.
// Slow_Clk checks are compiled only with QL_SLOW_CLK_EN.
module tb_ql_al4s3b_cell_macro;
  logic clk;
  logic rst_n;
  logic a_c0, a_r0, a_c1, a_r1;
  logic b_c0, b_r0, b_c1, b_r1;
`ifdef QL_SLOW_CLK_EN
  logic a_sl, b_sl;
`endif

  int ncmp = 0;
  int nerr = 0;
  int rises;
  logic prev_b;

  ql_al4s3b_cell_macro #(
    .TICK_COUNT(3)
  ) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .Sys_Clk0     (a_c0),
    .Sys_Clk0_Rst (a_r0),
    .Sys_Clk1     (a_c1),
    .Sys_Clk1_Rst (a_r1)
`ifdef QL_SLOW_CLK_EN
    ,
    .Slow_Clk     (a_sl)
`endif
  );

  ql_al4s3b_cell_macro #(
    .CLK0_DIV   (6),
    .CLK1_DIV   (12),
    .TICK_COUNT (3)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .Sys_Clk0     (b_c0),
    .Sys_Clk0_Rst (b_r0),
    .Sys_Clk1     (b_c1),
    .Sys_Clk1_Rst (b_r1)
`ifdef QL_SLOW_CLK_EN
    ,
    .Slow_Clk     (b_sl)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int n,
                     input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s @E%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a_c0"}, -1, a_c0, 1'b0);
    chk({tag, "_a_r0"}, -1, a_r0, 1'b1);
    chk({tag, "_a_c1"}, -1, a_c1, 1'b0);
    chk({tag, "_a_r1"}, -1, a_r1, 1'b1);
    chk({tag, "_b_c0"}, -1, b_c0, 1'b0);
    chk({tag, "_b_r0"}, -1, b_r0, 1'b1);
`ifdef QL_SLOW_CLK_EN
    chk({tag, "_a_sl"}, -1, a_sl, 1'b0);
`endif
  endtask

  // Edge n is E_n, counted from the first rising edge after release.
  task automatic run_seq(input int ncyc);
    logic e;
    rises = 0;
    prev_b = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      #1;
      e = (n >= 2) && ((n % 2) == 0);
      chk("a_c0", n, a_c0, e);
      chk("a_r0", n, a_r0, (n < 2));
      e = (n >= 3) && ((((n - 3) / 2) % 2) == 0);
      chk("a_c1", n, a_c1, e);
      chk("a_r1", n, a_r1, (n < 3));
      e = (n >= 4) && ((((n - 4) / 3) % 2) == 0);
      chk("b_c0", n, b_c0, e);
      chk("b_r0", n, b_r0, (n < 4));
      e = (n >= 7) && ((((n - 7) / 6) % 2) == 0);
      chk("b_c1", n, b_c1, e);
      chk("b_r1", n, b_r1, (n < 7));
`ifdef QL_SLOW_CLK_EN
      e = (n >= 5) && ((((n - 5) / 4) % 2) == 0);
      chk("a_sl", n, a_sl, e);
      chk("b_sl", n, b_sl, e);
`endif
      if (b_c0 && !prev_b && n >= 4 && n < 64) rises++;
      prev_b = b_c0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk_reset("rst");

    rst_n = 1'b1;
    run_seq(64);
    chk("b_c0_rises60", 63, 1'(rises == 10), 1'b1);

    @(posedge clk);
    #1;
    chk("a_c0_pre_mid", 64, a_c0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("mid");

    repeat (3) @(negedge clk);
    chk_reset("hold");
    rst_n = 1'b1;
    run_seq(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
